// File: rtl/p2s_ctrl_pkg.sv
// Shared state encoding and counter-width helper for the serial framer.
// The GUARD state is only reachable when the block is built with P2S_GUARD_EN.
package p2s_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_WAIT  = 2'd2,
      S_GUARD = 2'd3
   } state_e;

   // A counter over n states never needs fewer than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/p2s_shift_unit.sv
// MSB-first WIDTH-bit shift register with bit position counter.
// It holds its contents whenever neither load nor advance is asserted, which gives the stall hold.
module p2s_shift_unit
   import p2s_ctrl_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             bit_o,
   output logic             first_o,
   output logic             last_o
);

   localparam int BW = cnt_w(WIDTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;

   // Load wins over advance: a new symbol arrives on the same edge as the last-bit handshake.
   always_comb begin
      sreg_d = sreg_q;
      bcnt_d = bcnt_q;
      if (load_i) begin
         sreg_d = data_i;
         bcnt_d = {BW{1'b0}};
      end else if (adv_i) begin
         sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
         bcnt_d = (bcnt_q == BIT_LAST) ? {BW{1'b0}} : bcnt_q + BW'(1'b1);
      end else begin
         sreg_d = sreg_q;
         bcnt_d = bcnt_q;
      end
   end

   // Shift register and bit counter state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sreg_q <= {WIDTH{1'b0}};
         bcnt_q <= {BW{1'b0}};
      end else begin
         sreg_q <= sreg_d;
         bcnt_q <= bcnt_d;
      end
   end

   assign bit_o   = sreg_q[WIDTH-1];
   assign first_o = (bcnt_q == {BW{1'b0}});
   assign last_o  = (bcnt_q == BIT_LAST);

endmodule

// File: rtl/p2s_frame_ctrl.sv
// Parallel-to-serial scheduler and framer: symbols in over valid/ready, bits out MSB-first with SOF/EOF.
// Define P2S_GUARD_EN to append GUARD_BITS zero bits after every frame.
module p2s_frame_ctrl
   import p2s_ctrl_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int FRAME_SYMS = 4,
   parameter int GUARD_BITS = 3,
   parameter int FCNT_W     = 16
) (
   input  logic              clk_sig,
   input  logic              reset_sig,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_data,
   output logic              ser_sof,
   output logic              ser_eof,
   output logic              underrun,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int SW = cnt_w(FRAME_SYMS);
   localparam logic [SW-1:0] SYM_LAST = SW'(FRAME_SYMS - 1);
`ifdef P2S_GUARD_EN
   localparam int GW = cnt_w(GUARD_BITS);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_BITS - 1);
   logic [GW-1:0] guard_q;
`endif

   state_e            state_q;
   logic [SW-1:0]     sym_q;
   logic [FCNT_W-1:0] frame_q;
   logic              underrun_q;

   logic in_shift, last_hs, frame_end, accept;
   logic sh_bit, sh_first, sh_last;

   // Handshake decode; in_ready is forced low for as long as reset is held.
   always_comb begin
      in_shift  = (state_q == S_SHIFT);
      last_hs   = in_shift && sh_last && ser_ready;
      frame_end = last_hs && (sym_q == SYM_LAST);
`ifdef P2S_GUARD_EN
      in_ready  = !reset_sig && ((state_q == S_IDLE) || (state_q == S_WAIT) || (last_hs && !frame_end));
`else
      in_ready  = !reset_sig && ((state_q == S_IDLE) || (state_q == S_WAIT) || last_hs);
`endif
      accept    = in_valid && in_ready;
   end

   p2s_shift_unit #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk_i   (clk_sig),
      .rst_i   (reset_sig),
      .load_i  (accept),
      .adv_i   (in_shift && ser_ready),
      .data_i  (in_data),
      .bit_o   (sh_bit),
      .first_o (sh_first),
      .last_o  (sh_last)
   );

   // Frame FSM with symbol/frame counters and the registered underrun pulse.
   always_ff @(posedge clk_sig or posedge reset_sig) begin
      if (reset_sig) begin
         state_q    <= S_IDLE;
         sym_q      <= {SW{1'b0}};
         frame_q    <= {FCNT_W{1'b0}};
         underrun_q <= 1'b0;
`ifdef P2S_GUARD_EN
         guard_q    <= {GW{1'b0}};
`endif
      end else begin
         underrun_q <= last_hs && !frame_end && !in_valid;
         if (last_hs) begin
            sym_q <= frame_end ? {SW{1'b0}} : sym_q + SW'(1'b1);
         end
         if (frame_end) begin
            frame_q <= frame_q + FCNT_W'(1'b1);
         end
         case (state_q)
            S_IDLE, S_WAIT: begin
               if (accept) begin
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (last_hs) begin
                  if (accept) begin
                     state_q <= S_SHIFT;
                  end else if (frame_end) begin
`ifdef P2S_GUARD_EN
                     state_q <= S_GUARD;
`else
                     state_q <= S_IDLE;
`endif
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
`ifdef P2S_GUARD_EN
            S_GUARD: begin
               if (ser_ready) begin
                  if (guard_q == GUARD_LAST) begin
                     guard_q <= {GW{1'b0}};
                     state_q <= S_IDLE;
                  end else begin
                     guard_q <= guard_q + GW'(1'b1);
                  end
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Guard bits are zero with valid high and no frame flags.
   assign ser_valid = in_shift || (state_q == S_GUARD);
   assign ser_data  = in_shift && sh_bit;
   assign ser_sof   = in_shift && sh_first && (sym_q == {SW{1'b0}});
   assign ser_eof   = in_shift && sh_last && (sym_q == SYM_LAST);
   assign underrun  = underrun_q;
   assign frame_cnt = frame_q;

endmodule
